// File: rtl/sa_psum_deskew.sv
// Purpose: re-aligns the skewed per-column psum outputs of the PE array into one word per vector.
// Latency: a vector whose column 0 is valid in cycle T is pushed at the end of cycle T+NUM_COLS-1; o_valid rises in T+NUM_COLS.
// Backpressure: valid/ready pop at the FIFO head; a push into a full FIFO with no pop drops the word and sets o_overflow.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_start           one-cycle run start (honoured only in IDLE), i_num_vec sampled with it
//   i_psum_valid      column 0 of i_psum carries a valid result this cycle
//   i_psum[NUM_COLS]  skewed column words from the array (column n trails column 0 by n cycles)
//   o_data[NUM_COLS]  aligned word at the FIFO head, o_valid = FIFO not empty, i_ready = downstream accepts
//   o_busy, o_done    run in progress / one-cycle end-of-run pulse
//   o_overflow        sticky, an aligned word was dropped during this run
//
// Build option: define SA_DESKEW_RELU_EN to clamp negative column words to zero on the way into the FIFO.

module sa_psum_deskew #(
    parameter int ADD_DATAWIDTH = 32,
    parameter int NUM_COLS      = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic [CNT_WIDTH-1:0]     i_num_vec,
    input  logic                     i_psum_valid,
    input  logic [ADD_DATAWIDTH-1:0] i_psum [NUM_COLS],
    output logic [ADD_DATAWIDTH-1:0] o_data [NUM_COLS],
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_overflow
);

    // Column 0 is the earliest column, so it needs the longest delay.
    localparam int SKEW = NUM_COLS - 1;
    localparam int PW   = $clog2(FIFO_DEPTH);

    localparam logic [PW:0]          PTR_ONE = {{PW{1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   start_acc;

    logic [CNT_WIDTH-1:0] num_vec;
    logic [CNT_WIDTH-1:0] vec_cnt;

    // ------------------------------------------------------------------
    // Valid shift register: only valids seen while running are tracked.
    // The oldest stage lines up with the completed aligned word.
    // ------------------------------------------------------------------
    logic [SKEW-1:0] vld_sr;
    logic            vld_in;
    logic            push_stb;

    assign vld_in   = i_psum_valid && (state == S_RUN);
    assign push_stb = vld_sr[SKEW-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= vld_in;
            for (int i = 1; i < SKEW; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-column deskew delay lines. Column n is delayed SKEW-n cycles;
    // the last column is used straight from the input. The delay lines
    // run freely: only the push strobe decides what gets stored.
    // ------------------------------------------------------------------
    logic [ADD_DATAWIDTH-1:0] aligned   [NUM_COLS];
    logic [ADD_DATAWIDTH-1:0] push_word [NUM_COLS];

    genvar c;
    generate
        for (c = 0; c < NUM_COLS; c++) begin : g_col
            localparam int D = SKEW - c;
            if (D == 0) begin : g_pass
                assign aligned[c] = i_psum[c];
            end else begin : g_dly
                logic [ADD_DATAWIDTH-1:0] dly [D];

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int i = 0; i < D; i++) begin
                            dly[i] <= '0;
                        end
                    end else begin
                        dly[0] <= i_psum[c];
                        for (int i = 1; i < D; i++) begin
                            dly[i] <= dly[i-1];
                        end
                    end
                end

                assign aligned[c] = dly[D-1];
            end
        end
    endgenerate

    // Optional ReLU clamp sits combinationally in the push path.
    always_comb begin
        for (int i = 0; i < NUM_COLS; i++) begin
`ifdef SA_DESKEW_RELU_EN
            push_word[i] = aligned[i][ADD_DATAWIDTH-1] ? '0 : aligned[i];
`else
            push_word[i] = aligned[i];
`endif
        end
    end

    // ------------------------------------------------------------------
    // First-word-fall-through FIFO of aligned words. Pointers carry one
    // extra wrap bit so full and empty are distinguishable.
    // ------------------------------------------------------------------
    logic [ADD_DATAWIDTH-1:0] mem [FIFO_DEPTH][NUM_COLS];
    logic [PW:0]              wr_ptr;
    logic [PW:0]              rd_ptr;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     pop;
    logic                     wr_en;
    logic                     drop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                        (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    assign pop   = !fifo_empty && i_ready;
    // A pop in the same cycle frees the head slot, so a full FIFO can
    // still accept the incoming word.
    assign wr_en = push_stb && (!fifo_full || pop);
    assign drop  = push_stb && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < FIFO_DEPTH; d++) begin
                for (int i = 0; i < NUM_COLS; i++) begin
                    mem[d][i] <= '0;
                end
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_COLS; i++) begin
                mem[wr_ptr[PW-1:0]][i] <= push_word[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_COLS; i++) begin
            o_data[i] = mem[rd_ptr[PW-1:0]][i];
        end
    end

    assign o_valid = !fifo_empty;

    // ------------------------------------------------------------------
    // Run bookkeeping. Every push strobe counts as a vector, stored or
    // dropped, so a run with overflow still terminates.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_vec <= '0;
            vec_cnt <= '0;
        end else if (start_acc) begin
            num_vec <= i_num_vec;
            vec_cnt <= '0;
        end else if (push_stb) begin
            vec_cnt <= vec_cnt + CNT_ONE;
        end
    end

    // A drop in the start cycle belongs to the previous run's tail but is
    // still reported, so set has priority over the start-time clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_overflow <= 1'b0;
        end else if (drop) begin
            o_overflow <= 1'b1;
        end else if (start_acc) begin
            o_overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Run controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    start_acc = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // Finish only once every vector was counted and the
                // buffered words have all been taken downstream.
                if ((vec_cnt == num_vec) && fifo_empty) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_busy = (state == S_RUN);
    assign o_done = (state == S_DONE);

endmodule
